mic_measure_sequencer: RTL
==========================

// Module: mic_measure_sequencer
// PURPOSE
//  Controller that sequences the mic frequency-measurement datapath: clears and
//  gates the external edge counter for a fixed window, latches the count, hands
//  it to the BCD converter via start/done handshake, then publishes the result.
//  Also qualifies a target tone: asserts tone_detect after MATCH_N consecutive
//  in-band measurements. Sits between the JA1 edge counter and the BCD/display path.
// PARAMETERS
//  CNT_W        10           width of counter value / published Hz value
//  GATE_CYCLES  100_000_000  clk cycles counter is enabled per window (1 s @100 MHz)
//  F_LO         400          lower bound of target band, inclusive (Hz)
//  F_HI         600          upper bound of target band, inclusive (Hz)
//  MATCH_N      3            consecutive in-band windows needed for tone_detect
//  BCD_TIMEOUT  64           max clk cycles waiting for bcd_done
// PORTS
//  clk          in   1      100 MHz system clock
//  rst          in   1      synchronous reset, active-high
//  enable       in   1      run continuous measurements while high
//  cnt_value    in   CNT_W  edge count from counter (saturates at all-ones)
//  cnt_clr      out  1      one-cycle clear pulse to counter
//  cnt_en       out  1      counter gate; high only during GATE
//  bcd_start    out  1      one-cycle conversion request
//  bcd_bin      out  CNT_W  binary to converter; held stable from start until done
//  bcd_done     in   1      converter completion pulse
//  hz_value     out  CNT_W  last published measurement
//  hz_valid     out  1      one-cycle pulse when hz_value updates
//  overflow     out  1      last published measurement saturated
//  tone_detect  out  1      MATCH_N consecutive in-band windows seen
//  conv_err     out  1      sticky: a conversion timed out; cleared only by rst
//  busy         out  1      high in every state except IDLE
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; gate counter, match counter, meas reg 0.
//  - States: IDLE -> CLEAR -> GATE -> LATCH -> CONVERT -> UPDATE.
//  - IDLE: enable=1 -> CLEAR next cycle.
//  - CLEAR: cnt_clr=1 exactly one cycle -> GATE.
//  - GATE: cnt_en=1 for exactly GATE_CYCLES consecutive cycles -> LATCH.
//    enable=0 during GATE: abort to IDLE next cycle, cnt_en drops, no publish,
//    match counter and tone_detect unchanged.
//  - LATCH: cnt_en=0; one settle cycle; meas<=cnt_value, ovf<=(cnt_value=all ones).
//  - CONVERT: bcd_start=1 on first cycle only; bcd_bin=meas throughout.
//    bcd_done accepted on any CONVERT cycle incl. first -> UPDATE.
//    No done within BCD_TIMEOUT cycles: conv_err<=1, skip publish, -> CLEAR
//    if enable else IDLE; match counter reset to 0.
//    enable drop in CONVERT/LATCH does not abort; window completes.
//  - UPDATE (1 cycle): hz_value<=meas, overflow<=ovf, hz_valid=1.
//    In-band = F_LO<=meas<=F_HI and !ovf: match_cnt+1 saturating at MATCH_N;
//    else match_cnt<=0. tone_detect registered = (new match_cnt==MATCH_N),
//    visible same cycle as hz_valid. Then CLEAR if enable, else IDLE.
//  - Window period (fast converter, done in first CONVERT cycle):
//    GATE_CYCLES+4 cycles CLEAR-to-CLEAR.
//  - rst mid-operation: returns to reset state next edge, regardless of state.
//  - Unsigned compares; no arithmetic on meas beyond compare.
// TESTING (bench GATE_CYCLES=1000, MATCH_N=3, F_LO=400, F_HI=600)
//  1 rst, enable=1, model counter, 500 edges/window, done 5 cycles after start
//    -> cnt_en high exactly 1000 cycles; hz_value=500, hz_valid 1 cycle; bcd_bin=500.
//  2 three windows of 500 then one of 700 -> tone_detect 0,0,1 then 0 at 4th hz_valid.
//  3 cnt_value=1023 at LATCH -> overflow=1, match_cnt cleared, tone_detect=0.
//  4 enable=0 at gate cycle 400 -> IDLE next cycle, cnt_en=0, no hz_valid, busy=0.
//  5 bcd_done never asserted -> conv_err=1 after 64 CONVERT cycles, no hz_valid,
//    new cnt_clr follows; conv_err stays 1 until rst.
//  6 rst pulsed during CONVERT -> all outputs 0 next cycle, bcd_start never repeats.

Source files
------------

// File: rtl/mic_measure_sequencer.sv
// Sequencer for the mic frequency-measurement path: gated edge-count window,
// BCD conversion handshake, result publish and in-band tone qualification.
module mic_measure_sequencer #(
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned F_LO        = 400,
    parameter int unsigned F_HI        = 600,
    parameter int unsigned MATCH_N     = 3,
    parameter int unsigned BCD_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] cnt_value_i,
    output logic             cnt_clr_o,
    output logic             cnt_en_o,
    output logic             bcd_start_o,
    output logic [CNT_W-1:0] bcd_bin_o,
    input  logic             bcd_done_i,
    output logic [CNT_W-1:0] hz_value_o,
    output logic             hz_valid_o,
    output logic             overflow_o,
    output logic             tone_detect_o,
    output logic             conv_err_o,
    output logic             busy_o
);

    localparam int unsigned GW = $clog2(GATE_CYCLES + 1);
    localparam int unsigned TW = $clog2(BCD_TIMEOUT + 1);
    localparam int unsigned MW = $clog2(MATCH_N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_LATCH,
        S_CONVERT,
        S_UPDATE
    } state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
    logic [TW-1:0]    conv_cnt_q, conv_cnt_d;
    logic [CNT_W-1:0] meas_q, meas_d;
    logic             ovf_q, ovf_d;
    logic [MW-1:0]    match_q, match_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             cnt_en_q, cnt_en_d;
    logic             bcd_start_q, bcd_start_d;
    logic [CNT_W-1:0] hz_value_q, hz_value_d;
    logic             hz_valid_q, hz_valid_d;
    logic             overflow_q, overflow_d;
    logic             tone_q, tone_d;
    logic             conv_err_q, conv_err_d;
    logic             busy_q, busy_d;

    logic             gate_last_c;
    logic             conv_timeout_c;
    logic             in_band_c;
    logic [MW-1:0]    match_upd_c;

    assign gate_last_c    = (gate_cnt_q == GW'(GATE_CYCLES - 1));
    assign conv_timeout_c = !bcd_done_i && (conv_cnt_q == TW'(BCD_TIMEOUT - 1));
    assign in_band_c      = !ovf_q && (meas_q >= CNT_W'(F_LO)) && (meas_q <= CNT_W'(F_HI));
    assign match_upd_c    = !in_band_c                 ? '0 :
                            (match_q == MW'(MATCH_N))  ? match_q :
                                                         match_q + MW'(1);

    // State, datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            gate_cnt_q  <= '0;
            conv_cnt_q  <= '0;
            meas_q      <= '0;
            ovf_q       <= 1'b0;
            match_q     <= '0;
            cnt_clr_q   <= 1'b0;
            cnt_en_q    <= 1'b0;
            bcd_start_q <= 1'b0;
            hz_value_q  <= '0;
            hz_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            tone_q      <= 1'b0;
            conv_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gate_cnt_q  <= gate_cnt_d;
            conv_cnt_q  <= conv_cnt_d;
            meas_q      <= meas_d;
            ovf_q       <= ovf_d;
            match_q     <= match_d;
            cnt_clr_q   <= cnt_clr_d;
            cnt_en_q    <= cnt_en_d;
            bcd_start_q <= bcd_start_d;
            hz_value_q  <= hz_value_d;
            hz_valid_q  <= hz_valid_d;
            overflow_q  <= overflow_d;
            tone_q      <= tone_d;
            conv_err_q  <= conv_err_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic; a gate abort wins over the last gate cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (enable_i) state_d = S_CLEAR;
            S_CLEAR:   state_d = S_GATE;
            S_GATE: begin
                if (!enable_i)        state_d = S_IDLE;
                else if (gate_last_c) state_d = S_LATCH;
            end
            S_LATCH:   state_d = S_CONVERT;
            S_CONVERT: begin
                if (bcd_done_i)          state_d = S_UPDATE;
                else if (conv_timeout_c) state_d = enable_i ? S_CLEAR : S_IDLE;
            end
            S_UPDATE:  state_d = enable_i ? S_CLEAR : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        gate_cnt_d  = '0;
        conv_cnt_d  = '0;
        meas_d      = meas_q;
        ovf_d       = ovf_q;
        match_d     = match_q;
        hz_value_d  = hz_value_q;
        overflow_d  = overflow_q;
        tone_d      = tone_q;
        conv_err_d  = conv_err_q;
        cnt_clr_d   = (state_d == S_CLEAR);
        cnt_en_d    = (state_d == S_GATE);
        bcd_start_d = (state_d == S_CONVERT) && (state_q == S_LATCH);
        hz_valid_d  = (state_d == S_UPDATE);
        busy_d      = (state_d != S_IDLE);

        if (state_q == S_GATE) gate_cnt_d = gate_cnt_q + GW'(1);

        if (state_q == S_LATCH) begin
            meas_d = cnt_value_i;
            ovf_d  = &cnt_value_i;
        end

        if (state_q == S_CONVERT) begin
            conv_cnt_d = conv_cnt_q + TW'(1);
            if (conv_timeout_c) begin
                conv_err_d = 1'b1;
                match_d    = '0;
                tone_d     = 1'b0;
            end
        end

        if (state_d == S_UPDATE) begin
            hz_value_d = meas_q;
            overflow_d = ovf_q;
            match_d    = match_upd_c;
            tone_d     = (match_upd_c == MW'(MATCH_N));
        end
    end

    assign cnt_clr_o     = cnt_clr_q;
    assign cnt_en_o      = cnt_en_q;
    assign bcd_start_o   = bcd_start_q;
    assign bcd_bin_o     = meas_q;
    assign hz_value_o    = hz_value_q;
    assign hz_valid_o    = hz_valid_q;
    assign overflow_o    = overflow_q;
    assign tone_detect_o = tone_q;
    assign conv_err_o    = conv_err_q;
    assign busy_o        = busy_q;

endmodule
